// File: rtl/ddr2_dqs_strobe_seq.sv
// DQS strobe sequencer for one DDR2 byte lane: drives the write preamble/burst/postamble
// on the SSTL18 pad and opens and checks the read strobe receive window.
module ddr2_dqs_strobe_seq #(
  parameter int WL   = 2,
  parameter int RL   = 3,
  parameter int BL   = 4,
  parameter int TURN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_ack,
  output logic rd_ack,
  output logic busy,
  output logic pad_a,
  output logic pad_ts,
  output logic pad_ri,
  input  logic pad_z,
  output logic rd_beat,
  output logic rd_err
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WLAT   = 4'd1,
    WPRE   = 4'd2,
    WBURST = 4'd3,
    WPOST  = 4'd4,
    RLAT   = 4'd5,
    RPRE   = 4'd6,
    RBURST = 4'd7,
    RPOST  = 4'd8,
    TGAP   = 4'd9
  } state_t;

  // Terminal counts; values for skipped states (latency 1, TURN 0) are never compared.
  localparam logic [4:0] WLAT_LAST  = 5'(WL - 2);
  localparam logic [4:0] RLAT_LAST  = 5'(RL - 2);
  localparam logic [4:0] BURST_LAST = 5'(BL - 1);
  localparam logic [4:0] TGAP_LAST  = 5'(TURN - 1);

  state_t     state_r;
  logic [4:0] cnt_r;

  // Strobe level for a burst beat: beat 0 is high, then alternating.
  function automatic logic strobe_bit(input logic [4:0] beat);
    return ~beat[0];
  endfunction

  // Sequencer FSM; every pad output is loaded together with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      busy    <= 1'b0;
      pad_a   <= 1'b0;
      pad_ts  <= 1'b0;
      pad_ri  <= 1'b0;
      rd_beat <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_beat <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 5'd0;
          if (rd_req) begin
            rd_ack <= 1'b1;
            rd_err <= 1'b0;
            busy   <= 1'b1;
            if (RL == 1) begin
              state_r <= RPRE;
              pad_ri  <= 1'b1;
            end else begin
              state_r <= RLAT;
            end
          end else if (wr_req) begin
            wr_ack <= 1'b1;
            busy   <= 1'b1;
            if (WL == 1) begin
              state_r <= WPRE;
              pad_ts  <= 1'b1;
              pad_a   <= 1'b0;
            end else begin
              state_r <= WLAT;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        WLAT: begin
          if (cnt_r == WLAT_LAST) begin
            state_r <= WPRE;
            cnt_r   <= 5'd0;
            pad_ts  <= 1'b1;
            pad_a   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end

        WPRE: begin
          state_r <= WBURST;
          cnt_r   <= 5'd0;
          pad_ts  <= 1'b1;
          pad_a   <= strobe_bit(5'd0);
        end

        WBURST: begin
          if (cnt_r == BURST_LAST) begin
            state_r <= WPOST;
            cnt_r   <= 5'd0;
            pad_ts  <= 1'b1;
            pad_a   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 5'd1;
            pad_a <= strobe_bit(cnt_r + 5'd1);
          end
        end

        WPOST: begin
          cnt_r  <= 5'd0;
          pad_ts <= 1'b0;
          pad_a  <= 1'b0;
          if (TURN == 0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= TGAP;
          end
        end

        RLAT: begin
          if (cnt_r == RLAT_LAST) begin
            state_r <= RPRE;
            cnt_r   <= 5'd0;
            pad_ri  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end

        RPRE: begin
          if (pad_z != 1'b0) begin
            rd_err <= 1'b1;
          end
          state_r <= RBURST;
          cnt_r   <= 5'd0;
          pad_ri  <= 1'b1;
        end

        // Each beat is checked at the end of its cycle and reported one cycle later.
        RBURST: begin
          if (pad_z != strobe_bit(cnt_r)) begin
            rd_err <= 1'b1;
          end
          rd_beat <= 1'b1;
          if (cnt_r == BURST_LAST) begin
            state_r <= RPOST;
            cnt_r   <= 5'd0;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end

        RPOST: begin
          if (pad_z != 1'b0) begin
            rd_err <= 1'b1;
          end
          cnt_r  <= 5'd0;
          pad_ri <= 1'b0;
          if (TURN == 0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= TGAP;
          end
        end

        TGAP: begin
          if (cnt_r == TGAP_LAST) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= 5'd0;
          busy    <= 1'b0;
          pad_a   <= 1'b0;
          pad_ts  <= 1'b0;
          pad_ri  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_dqs_strobe_seq.sv
// Scoreboard bench for ddr2_dqs_strobe_seq: a default instance and a WL=RL=1, BL=2, TURN=0
// instance; expected per-cycle outputs are queued as stimulus is issued and popped each cycle.
module tb_ddr2_dqs_strobe_seq;

  localparam int WL = 2, RL = 3, BL = 4, TURN = 1;
  localparam int WLB = 1, RLB = 1, BLB = 2, TURNB = 0;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic wr_req_a, rd_req_a, z_a, wr_ack_a, rd_ack_a, busy_a, a_a, ts_a, ri_a, beat_a, err_a;
  logic wr_req_b, rd_req_b, z_b, wr_ack_b, rd_ack_b, busy_b, a_b, ts_b, ri_b, beat_b, err_b;

  logic [7:0] exp_q[$];
  logic       z_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ddr2_dqs_strobe_seq #(.WL(WL), .RL(RL), .BL(BL), .TURN(TURN)) dut (
    .clk(clk), .reset(rst_a), .wr_req(wr_req_a), .rd_req(rd_req_a),
    .wr_ack(wr_ack_a), .rd_ack(rd_ack_a), .busy(busy_a), .pad_a(a_a), .pad_ts(ts_a),
    .pad_ri(ri_a), .pad_z(z_a), .rd_beat(beat_a), .rd_err(err_a));

  ddr2_dqs_strobe_seq #(.WL(WLB), .RL(RLB), .BL(BLB), .TURN(TURNB)) dut_b (
    .clk(clk), .reset(rst_b), .wr_req(wr_req_b), .rd_req(rd_req_b),
    .wr_ack(wr_ack_b), .rd_ack(rd_ack_b), .busy(busy_b), .pad_a(a_b), .pad_ts(ts_b),
    .pad_ri(ri_b), .pad_z(z_b), .rd_beat(beat_b), .rd_err(err_b));

  // Output vector layout: {busy, wr_ack, rd_ack, ts, a, ri, rd_beat, rd_err}
  function automatic logic [7:0] obs_a();
    return {busy_a, wr_ack_a, rd_ack_a, ts_a, a_a, ri_a, beat_a, err_a};
  endfunction

  function automatic logic [7:0] obs_b();
    return {busy_b, wr_ack_b, rd_ack_b, ts_b, a_b, ri_b, beat_b, err_b};
  endfunction

  // Write accepted at E0: expectations for cycles 1 .. first idle cycle.
  task automatic push_write(input int wl, input int bl, input int turn, input logic err);
    int len;
    logic ts, a;
    len = wl + bl + 2 + turn;
    for (int k = 1; k <= len; k++) begin
      ts = (k >= wl) && (k <= wl + bl + 1);
      a  = (k >= wl + 1) && (k <= wl + bl) && (((k - wl - 1) % 2) == 0);
      exp_q.push_back({(k < len), (k == 1), 1'b0, ts, a, 1'b0, 1'b0, err});
      z_q.push_back(1'b0);
    end
  endtask

  // Read accepted at E0; stuck drives z=1 throughout, otherwise the legal strobe pattern.
  task automatic push_read(input int rl, input int bl, input int turn, input logic stuck);
    int len;
    logic ri, beat, err, z;
    len = rl + bl + 2 + turn;
    for (int k = 1; k <= len; k++) begin
      ri   = (k >= rl) && (k <= rl + bl + 1);
      beat = (k >= rl + 2) && (k <= rl + bl + 1);
      err  = stuck && (k >= rl + 1);
      z    = stuck ? 1'b1 : ((k >= rl + 1) && (k <= rl + bl) && (((k - rl - 1) % 2) == 0));
      exp_q.push_back({(k < len), 1'b0, (k == 1), 1'b0, 1'b0, ri, beat, err});
      z_q.push_back(z);
    end
  endtask

  task automatic push_idle(input int n, input logic err);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({7'b0000000, err});
      z_q.push_back(1'b0);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, then drive this cycle's pad_z.
  task automatic step(input bit sel, output logic [7:0] obs);
    logic z;
    @(posedge clk);
    #1;
    obs = sel ? obs_b() : obs_a();
    z = (z_q.size() > 0) ? z_q.pop_front() : 1'b0;
    if (sel) z_b = z;
    else z_a = z;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    #2;
    n_cmp++;
    if (obs_a() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_a: got %b want %b", obs_a(), 8'h00);
    end
    n_cmp++;
    if (obs_b() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_b: got %b want %b", obs_b(), 8'h00);
    end
    step(1'b0, obs);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(1'b0, obs);
    n_cmp++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_write();
    logic [7:0] obs, exp;
    int k = 0;
    @(posedge clk); #1;
    wr_req_a = 1'b1;
    push_write(WL, BL, TURN, 1'b0);
    while (exp_q.size() > 0) begin
      step(1'b0, obs);
      k++;
      if (k == 1) wr_req_a = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL write cyc%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_read(input logic stuck);
    logic [7:0] obs, exp;
    int k = 0;
    @(posedge clk); #1;
    rd_req_a = 1'b1;
    push_read(RL, BL, TURN, stuck);
    if (stuck) push_idle(3, 1'b1);
    while (exp_q.size() > 0) begin
      step(1'b0, obs);
      k++;
      if (k == 1) rd_req_a = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL read stuck=%0b cyc%0d: got %b want %b", stuck, k, obs, exp);
      end
    end
  endtask

  task automatic test_both_requests();
    logic [7:0] obs, exp;
    int k = 0;
    int rd_len = RL + BL + 2 + TURN;
    @(posedge clk); #1;
    rd_req_a = 1'b1;
    wr_req_a = 1'b1;
    push_read(RL, BL, TURN, 1'b0);
    push_write(WL, BL, TURN, 1'b0);
    while (exp_q.size() > 0) begin
      step(1'b0, obs);
      k++;
      if (k == 1) rd_req_a = 1'b0;
      if (k == rd_len + 1) wr_req_a = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL both cyc%0d: got %b want %b", k, obs, exp);
      end
      n_cmp++;
      if ((obs[4] & obs[2]) !== 1'b0) begin
        n_fail++;
        $display("FAIL both ts_ri cyc%0d: got ts=%b ri=%b want not both", k, obs[4], obs[2]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] obs, exp;
    int k = 0;
    @(posedge clk); #1;
    wr_req_a = 1'b1;
    push_write(WL, BL, TURN, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, obs);
      if (c == 1) wr_req_a = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL midrst pre cyc%0d: got %b want %b", c, obs, exp);
      end
    end
    exp_q.delete();
    z_q.delete();
    #2;
    rst_a = 1'b1;
    #1;
    n_cmp++;
    if ({ts_a, a_a, busy_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst drop: got ts/a/busy=%b want 000", {ts_a, a_a, busy_a});
    end
    #1;
    rst_a = 1'b0;
    wr_req_a = 1'b1;
    push_write(WL, BL, TURN, 1'b0);
    while (exp_q.size() > 0) begin
      step(1'b0, obs);
      k++;
      if (k == 1) wr_req_a = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL midrst post cyc%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs, exp;
    int k = 0;
    @(posedge clk); #1;
    wr_req_b = 1'b1;
    push_write(WLB, BLB, TURNB, 1'b0);
    push_read(RLB, BLB, TURNB, 1'b0);
    while (exp_q.size() > 0) begin
      step(1'b1, obs);
      k++;
      if (k == 1) wr_req_b = 1'b0;
      if (k == 4) rd_req_b = 1'b1;
      if (k == 6) rd_req_b = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got %b want %b", k, obs, exp);
      end
      n_cmp++;
      if ((obs[4] & obs[2]) !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b ts_ri cyc%0d: got ts=%b ri=%b want not both", k, obs[4], obs[2]);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    wr_req_a = 1'b0; rd_req_a = 1'b0; z_a = 1'b0;
    wr_req_b = 1'b0; rd_req_b = 1'b0; z_b = 1'b0;
    test_reset();
    test_write();
    test_read(1'b0);
    test_read(1'b1);
    test_both_requests();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
